// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: latches one packed frame, drives the shared SISO through
// NUM_ITER full iterations (natural half, then interleaved half), keeps the extrinsic memory
// between halves and presents hard decisions once the last half has been collected.
module turbo_iter_ctrl #(
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned SYM_W      = 7,
  parameter int unsigned EXT_W      = 10,
  parameter int unsigned NUM_ITER   = 16,
  parameter int unsigned INTLV_STEP = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             frm_valid_i,
  output logic                             frm_ready_o,
  input  logic [FRAME_LEN*3*SYM_W-1:0]     frm_data_i,
  output logic                             siso_read_en_o,
  output logic [SYM_W-1:0]                 siso_sys_o,
  output logic [SYM_W-1:0]                 siso_enc_o,
  output logic [EXT_W-1:0]                 siso_ext_o,
  input  logic [EXT_W-1:0]                 siso_data_i,
  input  logic                             siso_done_i,
  output logic                             dec_valid_o,
  output logic [FRAME_LEN-1:0]             dec_data_o,
  input  logic                             dec_ready_i,
  output logic                             busy_o,
  output logic [$clog2(NUM_ITER+1)-1:0]    iter_o
);

  localparam int unsigned IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned ITER_W = $clog2(NUM_ITER + 1);
  localparam int unsigned SLOT_W = 3 * SYM_W;

  typedef enum logic [1:0] {StIdle, StFeed, StWait, StOut} state_e;

  state_e                         state_q, state_d;
  logic [FRAME_LEN*3*SYM_W-1:0]   frame_q;
  logic [EXT_W-1:0]               ext_q [FRAME_LEN];
  logic                           half_q, half_d;
  logic [ITER_W-1:0]              iter_q, iter_d;
  logic [IDX_W-1:0]               feed_idx_q, feed_idx_d;
  logic [CNT_W-1:0]               done_cnt_q, done_cnt_d;

  logic                           load_frame;
  logic                           ext_clr;
  logic                           ext_we;
  logic [IDX_W-1:0]               ext_waddr;
  logic [IDX_W-1:0]               done_idx;
  logic [IDX_W-1:0]               rd_idx;
  logic [EXT_W:0]                 sys_x, ext_x, dec_sum;

  // Interleaver address pi(i) = (i * INTLV_STEP) mod FRAME_LEN.
  function automatic logic [IDX_W-1:0] pi_f(input logic [IDX_W-1:0] idx);
    int unsigned p;
    p = (32'(idx) * INTLV_STEP) % FRAME_LEN;
    return IDX_W'(p);
  endfunction

  assign done_idx = done_cnt_q[IDX_W-1:0];
  assign rd_idx   = half_q ? pi_f(feed_idx_q) : feed_idx_q;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      half_q     <= 1'b0;
      iter_q     <= '0;
      feed_idx_q <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      iter_q     <= iter_d;
      feed_idx_q <= feed_idx_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Frame capture register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_q <= '0;
    end else if (load_frame) begin
      frame_q <= frm_data_i;
    end
  end

  // Extrinsic memory: cleared per frame, written by in-window SISO results.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < FRAME_LEN; k++) ext_q[k] <= '0;
    end else if (ext_clr) begin
      for (int k = 0; k < FRAME_LEN; k++) ext_q[k] <= '0;
    end else if (ext_we) begin
      ext_q[ext_waddr] <= siso_data_i;
    end
  end

  // Next-state, counters and extrinsic write control.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    iter_d     = iter_q;
    feed_idx_d = feed_idx_q;
    done_cnt_d = done_cnt_q;
    load_frame = 1'b0;
    ext_clr    = 1'b0;
    ext_we     = 1'b0;
    ext_waddr  = half_q ? pi_f(done_idx) : done_idx;

    // Results may arrive while the half is still being fed; excess pulses are dropped.
    if ((state_q == StFeed || state_q == StWait) && siso_done_i &&
        (done_cnt_q < CNT_W'(FRAME_LEN))) begin
      ext_we     = 1'b1;
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (frm_valid_i) begin
          load_frame = 1'b1;
          ext_clr    = 1'b1;
          half_d     = 1'b0;
          iter_d     = '0;
          feed_idx_d = '0;
          done_cnt_d = '0;
          state_d    = StFeed;
        end
      end
      StFeed: begin
        if (feed_idx_q == IDX_W'(FRAME_LEN - 1)) begin
          feed_idx_d = '0;
          state_d    = StWait;
        end else begin
          feed_idx_d = feed_idx_q + IDX_W'(1);
        end
      end
      StWait: begin
        if (done_cnt_q == CNT_W'(FRAME_LEN)) begin
          done_cnt_d = '0;
          feed_idx_d = '0;
          if (!half_q) begin
            half_d  = 1'b1;
            state_d = StFeed;
          end else if (iter_q < ITER_W'(NUM_ITER - 1)) begin
            iter_d  = iter_q + ITER_W'(1);
            half_d  = 1'b0;
            state_d = StFeed;
          end else begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (dec_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SISO feed datapath; data forced to zero outside FEED.
  always_comb begin
    siso_read_en_o = (state_q == StFeed);
    siso_sys_o     = '0;
    siso_enc_o     = '0;
    siso_ext_o     = '0;
    if (state_q == StFeed) begin
      siso_sys_o = frame_q[32'(rd_idx) * SLOT_W +: SYM_W];
      siso_enc_o = half_q ? frame_q[32'(feed_idx_q) * SLOT_W + 2 * SYM_W +: SYM_W]
                          : frame_q[32'(feed_idx_q) * SLOT_W + SYM_W +: SYM_W];
      siso_ext_o = ext_q[rd_idx];
    end
  end

  // Hard decisions: sign of (sys + ext) at EXT_W+1 bits, so no overflow is possible.
  always_comb begin
    sys_x      = '0;
    ext_x      = '0;
    dec_sum    = '0;
    dec_data_o = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      sys_x = {{(EXT_W + 1 - SYM_W){frame_q[k * SLOT_W + SYM_W - 1]}},
               frame_q[k * SLOT_W +: SYM_W]};
      ext_x = {ext_q[k][EXT_W-1], ext_q[k]};
      dec_sum = sys_x + ext_x;
      dec_data_o[k] = (state_q == StOut) & dec_sum[EXT_W];
    end
  end

  assign frm_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign dec_valid_o = (state_q == StOut);
  assign iter_o      = iter_q;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Scoreboard bench for turbo_iter_ctrl: a reference model predicts every SISO feed tuple and the
// final decisions of each frame; monitor processes pop and compare as the DUT presents them.
module tb_turbo_iter_ctrl;
  localparam int FL = 4;
  localparam int SW = 7;
  localparam int EW = 10;
  localparam int NI = 16;
  localparam int ST = 3;
  localparam int IW = $clog2(NI + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frm_valid = 1'b0;
  logic              frm_ready;
  logic [FL*3*SW-1:0] frm_data = '0;
  logic              rd_en;
  logic [SW-1:0]     s_sys, s_enc;
  logic [EW-1:0]     s_ext;
  logic [EW-1:0]     s_data = '0;
  logic              s_done = 1'b0;
  logic              dec_valid;
  logic [FL-1:0]     dec_data;
  logic              dec_ready = 1'b0;
  logic              busy;
  logic [IW-1:0]     iter;

  turbo_iter_ctrl #(.FRAME_LEN(FL), .SYM_W(SW), .EXT_W(EW), .NUM_ITER(NI), .INTLV_STEP(ST)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .frm_valid_i(frm_valid), .frm_ready_o(frm_ready),
    .frm_data_i(frm_data), .siso_read_en_o(rd_en), .siso_sys_o(s_sys), .siso_enc_o(s_enc),
    .siso_ext_o(s_ext), .siso_data_i(s_data), .siso_done_i(s_done), .dec_valid_o(dec_valid),
    .dec_data_o(dec_data), .dec_ready_i(dec_ready), .busy_o(busy), .iter_o(iter)
  );

  always #5 clk = ~clk;

  typedef struct { int sys; int enc; int ext; int it; } feed_t;
  typedef struct { int val; int due; } resp_t;

  feed_t   feed_q[$];
  int      dec_q[$];
  resp_t   pend_q[$];
  int      n_tests = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      siso_mode = 0;
  int      siso_lag = 1;
  bit      siso_extra = 1'b0;
  int      siso_ndone = 0;
  bit      siso_inject = 1'b0;
  int      vcycles = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural SISO: a pure function of the symbols it is fed.
  function automatic int siso_fn(input int mode, input int s, input int e, input int x);
    case (mode)
      0:       return 0;
      1:       return -20;
      default: return s - e + (x >>> 1);
    endcase
  endfunction

  // Reference model: whole-frame decode at the level of symbol arrays.
  task automatic model_frame(input int sys[FL], input int e1[FL], input int e2[FL],
                             input int mode, input bit abort);
    int ext[FL];
    int outv[FL];
    int addr[FL];
    int dec;
    feed_t f;
    for (int k = 0; k < FL; k++) ext[k] = 0;
    for (int it = 0; it < NI; it++) begin
      for (int h = 0; h < 2; h++) begin
        for (int i = 0; i < FL; i++) begin
          addr[i] = (h == 1) ? (i * ST) % FL : i;
          f.sys = sys[addr[i]];
          f.enc = (h == 1) ? e2[i] : e1[i];
          f.ext = ext[addr[i]];
          f.it  = it;
          feed_q.push_back(f);
          outv[i] = siso_fn(mode, f.sys, f.enc, f.ext);
        end
        for (int i = 0; i < FL; i++) ext[addr[i]] = outv[i];
      end
    end
    dec = 0;
    for (int k = 0; k < FL; k++) if (sys[k] + ext[k] < 0) dec |= (1 << k);
    if (!abort) dec_q.push_back(dec);
  endtask

  // SISO model: answers each strobe after siso_lag cycles; optionally adds stray done pulses.
  always @(negedge clk) begin
    cyc++;
    s_done = 1'b0;
    s_data = '0;
    if (rst_n) begin
      if (rd_en) begin
        resp_t r;
        r.val = siso_fn(siso_mode, int'($signed(s_sys)), int'($signed(s_enc)),
                        int'($signed(s_ext)));
        r.due = cyc + siso_lag;
        pend_q.push_back(r);
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        resp_t r;
        r = pend_q.pop_front();
        s_done = 1'b1;
        s_data = EW'(r.val);
        siso_ndone++;
        if (siso_ndone == FL) begin
          siso_ndone  = 0;
          siso_inject = siso_extra;
        end
      end else if (siso_inject) begin
        siso_inject = 1'b0;
        s_done = 1'b1;
        s_data = EW'($urandom);
      end else if (siso_extra && (frm_ready || dec_valid)) begin
        s_done = 1'b1;
        s_data = EW'($urandom);
      end
    end
  end

  // Feed monitor: every strobe must match the next predicted tuple; idle data must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (feed_q.size() == 0) begin
          check("feed_unexpected", 1, 0);
        end else begin
          feed_t f;
          f = feed_q.pop_front();
          check("feed_sys", int'($signed(s_sys)), f.sys);
          check("feed_enc", int'($signed(s_enc)), f.enc);
          check("feed_ext", int'($signed(s_ext)), f.ext);
          check("feed_iter", int'(iter), f.it);
        end
      end else begin
        check("idle_siso_data", int'({s_sys, s_enc, s_ext}), 0);
      end
    end
  end

  // Decision monitor: compares every valid cycle (stability), drives ready, pops on handshake.
  always @(negedge clk) begin
    dec_ready = 1'b0;
    if (!rst_n) begin
      vcycles = 0;
    end else if (dec_valid) begin
      if (dec_q.size() == 0) begin
        check("dec_unexpected", 1, 0);
      end else begin
        check("dec_data", int'(dec_data), dec_q[0]);
        // Hold off at least three valid cycles before accepting.
        if (vcycles >= 3 && $urandom_range(0, 1) == 1) begin
          dec_ready = 1'b1;
          void'(dec_q.pop_front());
          vcycles = 0;
        end else begin
          vcycles++;
        end
      end
    end else begin
      check("dec_data_idle", int'(dec_data), 0);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_frm_ready"}, int'(frm_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_dec_valid"}, int'(dec_valid), 0);
    check({tag, "_read_en"}, int'(rd_en), 0);
    check({tag, "_iter"}, int'(iter), 0);
    check({tag, "_outputs"}, int'({s_sys, s_enc, s_ext, dec_data}), 0);
  endtask

  task automatic run_frame(input int sys[FL], input int e1[FL], input int e2[FL],
                           input int mode, input int lag, input bit extra, input bit abort);
    int guard;
    bit ok;
    siso_mode  = mode;
    siso_lag   = lag;
    siso_extra = extra;
    model_frame(sys, e1, e2, mode, abort);
    ok = 1'b0;
    for (guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      if (frm_ready) begin ok = 1'b1; break; end
    end
    check("frm_ready_timeout", int'(ok), 1);
    for (int k = 0; k < FL; k++) begin
      frm_data[k*3*SW +: SW]        = SW'(sys[k]);
      frm_data[k*3*SW + SW +: SW]   = SW'(e1[k]);
      frm_data[k*3*SW + 2*SW +: SW] = SW'(e2[k]);
    end
    frm_valid = 1'b1;
    @(negedge clk);
    check("busy_after_accept", int'(busy), 1);
    // Junk frames while busy must be ignored.
    frm_data = {$urandom, $urandom, $urandom};
    repeat (10) @(negedge clk);
    frm_valid = 1'b0;
    if (abort) begin
      ok = 1'b0;
      for (guard = 0; guard < 5000; guard++) begin
        @(negedge clk);
        if (rd_en && iter == IW'(2)) begin ok = 1'b1; break; end
      end
      check("iter2_reached", int'(ok), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      feed_q.delete();
      pend_q.delete();
      siso_ndone  = 0;
      siso_inject = 1'b0;
      #1;
      check_idle("abort_reset");
      repeat (2) @(posedge clk);
      #2;
      check_idle("abort_hold");
      rst_n = 1'b1;
    end else begin
      ok = 1'b0;
      for (guard = 0; guard < 20000; guard++) begin
        @(negedge clk);
        if (dec_q.size() == 0) begin ok = 1'b1; break; end
      end
      check("frame_done_timeout", int'(ok), 1);
      check("feeds_remaining", feed_q.size(), 0);
      @(negedge clk);
      check("frm_ready_after_out", int'(frm_ready), 1);
    end
  endtask

  initial begin
    int sys[FL];
    int e1[FL];
    int e2[FL];
    repeat (2) @(negedge clk);
    check_idle("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Directed: zero-echo SISO, decisions are the systematic signs.
    sys = '{10, -5, 3, -1}; e1 = '{1, 2, 3, 4}; e2 = '{-1, -2, -3, -4};
    run_frame(sys, e1, e2, 0, 1, 1'b0, 1'b0);
    // Directed: constant -20 extrinsic overrides positive systematics.
    sys = '{10, 10, 10, 10};
    run_frame(sys, e1, e2, 1, 1, 1'b0, 1'b0);
    // Same random frame with 0- and 5-cycle SISO lag.
    for (int k = 0; k < FL; k++) begin
      sys[k] = $urandom_range(0, 127) - 64;
      e1[k]  = $urandom_range(0, 127) - 64;
      e2[k]  = $urandom_range(0, 127) - 64;
    end
    run_frame(sys, e1, e2, 2, 0, 1'b0, 1'b0);
    run_frame(sys, e1, e2, 2, 5, 1'b0, 1'b0);
    // Stray done pulses after each half and while idle/out.
    run_frame(sys, e1, e2, 2, 2, 1'b1, 1'b0);
    // Reset during iteration 2, then a clean frame.
    run_frame(sys, e1, e2, 2, 1, 1'b0, 1'b1);
    run_frame(sys, e1, e2, 2, 3, 1'b0, 1'b0);
    // Random frames.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < FL; k++) begin
        sys[k] = $urandom_range(0, 127) - 64;
        e1[k]  = $urandom_range(0, 127) - 64;
        e2[k]  = $urandom_range(0, 127) - 64;
      end
      run_frame(sys, e1, e2, $urandom_range(0, 2), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
